mod_addsub_pipe: RTL and testbench

Parametrised, pipelined modular adder/subtractor: computes (a + b) mod q or (a − b) mod q for operands in [0, q), selectable per transaction. Two register stages with valid/ready flow control on both sides sustain one result per clock under backpressure. Sits in the polynomial arithmetic datapath, feeding NTT butterflies and coefficient-wise add/sub, with q supplied per transaction so one instance serves multiple moduli.

---
 rtl/mod_addsub_pipe_if.sv | 27 ++
 rtl/mod_addsub_pipe.sv | 119 +++++++++++
 tb/tb_mod_addsub_pipe.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mod_addsub_pipe_if.sv
// Handshake and payload bundle for the pipelined modular adder/subtractor.
interface mod_addsub_pipe_if #(
    parameter int unsigned W = 23
);
    logic         valid_i;
    logic         ready_o;
    logic         op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] q_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] c_o;
    logic         range_err_o;

    // Arithmetic block side
    modport slave (
        input  valid_i, op_i, a_i, b_i, q_i, ready_i,
        output ready_o, valid_o, c_o, range_err_o
    );

    // Producer/consumer side
    modport master (
        output valid_i, op_i, a_i, b_i, q_i, ready_i,
        input  ready_o, valid_o, c_o, range_err_o
    );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined (a +/- b) mod q with valid/ready flow control on both sides.
// S1 holds the raw W+1-bit sum/difference; S2 holds the corrected result.
module mod_addsub_pipe #(
    parameter int unsigned W           = 23,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mod_addsub_pipe_if.slave  bus
);

    localparam int unsigned RW = W + 1;

    logic          v1_q;
    logic          op1_q;
    logic          err1_q;
    logic [W-1:0]  q1_q;
    logic [RW-1:0] r1_q;

    logic          v2_q;
    logic          err2_q;
    logic [W-1:0]  c2_q;

    logic          ld1_c;
    logic          ld2_c;
    logic          err_c;
    logic [RW-1:0] r_c;
    logic [RW-1:0] q1_ext_c;
    logic [W-1:0]  c_c;

    // S2 advances when it is empty or its token is being consumed; S1 accepts
    // whenever the pipe as a whole has room after this cycle.
    assign ld2_c       = v1_q && (!v2_q || bus.ready_i);
    assign bus.ready_o = !v1_q || !v2_q || bus.ready_i;
    assign ld1_c       = bus.valid_i && bus.ready_o;

    // Raw sum or two's-complement difference, one extra bit for carry/borrow
    always_comb begin
        r_c = RW'({1'b0, bus.a_i}) + RW'({1'b0, bus.b_i});
        if (bus.op_i) begin
            r_c = RW'({1'b0, bus.a_i}) - RW'({1'b0, bus.b_i});
        end
    end

    // Operand range flag, optionally compiled out
    generate
        if (CHECK_RANGE) begin : g_range
            assign err_c = (bus.a_i >= bus.q_i) || (bus.b_i >= bus.q_i);
        end else begin : g_no_range
            assign err_c = 1'b0;
        end
    endgenerate

    // Single conditional correction by q: subtract on add overflow, add on borrow
    always_comb begin
        q1_ext_c = RW'({1'b0, q1_q});
        c_c      = r1_q[W-1:0];
        if (!op1_q) begin
            if (r1_q >= q1_ext_c) begin
                c_c = W'(r1_q - q1_ext_c);
            end
        end else if (r1_q[W]) begin
            c_c = W'(r1_q + q1_ext_c);
        end
    end

    // S1 occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
        end else if (ld1_c) begin
            v1_q <= 1'b1;
        end else if (ld2_c) begin
            v1_q <= 1'b0;
        end
    end

    // S1 payload, loaded only on accept so a stalled token is never overwritten
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op1_q  <= 1'b0;
            err1_q <= 1'b0;
            q1_q   <= '0;
            r1_q   <= '0;
        end else if (ld1_c) begin
            op1_q  <= bus.op_i;
            err1_q <= err_c;
            q1_q   <= bus.q_i;
            r1_q   <= r_c;
        end
    end

    // S2 occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q <= 1'b0;
        end else if (ld2_c) begin
            v2_q <= 1'b1;
        end else if (bus.ready_i) begin
            v2_q <= 1'b0;
        end
    end

    // S2 payload, held stable while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c2_q   <= '0;
            err2_q <= 1'b0;
        end else if (ld2_c) begin
            c2_q   <= c_c;
            err2_q <= err1_q;
        end
    end

    assign bus.valid_o     = v2_q;
    assign bus.c_o         = c2_q;
    assign bus.range_err_o = err2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed boundaries, backpressure,
// range flag, mid-stream reset and a random scoreboard run (W=23 and W=32).
module tb_mod_addsub_pipe;

    localparam logic [22:0] Q    = 23'h7FE001;
    localparam logic [31:0] Q32  = 32'hFFFFFFFB;
    localparam int          NRND = 10000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a32;
    logic [31:0] b32;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_addsub_pipe_if #(.W(23)) if0   ();
    mod_addsub_pipe_if #(.W(23)) if_nr ();
    mod_addsub_pipe_if #(.W(32)) if32  ();

    mod_addsub_pipe #(.W(23), .CHECK_RANGE(1'b1)) u_dut (
        .clk_i (clk), .rst_ni (rst_n), .bus (if0.slave)
    );
    mod_addsub_pipe #(.W(23), .CHECK_RANGE(1'b0)) u_dut_nr (
        .clk_i (clk), .rst_ni (rst_n), .bus (if_nr.slave)
    );
    mod_addsub_pipe #(.W(32), .CHECK_RANGE(1'b1)) u_dut32 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if32.slave)
    );

    // Secondary instances follow the main handshake so their outputs run in lockstep
    assign if_nr.valid_i = if0.valid_i;
    assign if_nr.op_i    = if0.op_i;
    assign if_nr.a_i     = if0.a_i;
    assign if_nr.b_i     = if0.b_i;
    assign if_nr.q_i     = if0.q_i;
    assign if_nr.ready_i = if0.ready_i;
    assign if32.valid_i  = if0.valid_i;
    assign if32.op_i     = if0.op_i;
    assign if32.a_i      = a32;
    assign if32.b_i      = b32;
    assign if32.q_i      = Q32;
    assign if32.ready_i  = if0.ready_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned mod_ref(input bit op_v, input longint unsigned av,
                                                input longint unsigned bv, input longint unsigned qv);
        return op_v ? (av + qv - bv) % qv : (av + bv) % qv;
    endfunction

    // One isolated token: latency of two edges, then drained
    task automatic one(input string tag, input logic op_v, input logic [22:0] av,
                       input logic [22:0] bv, input logic [22:0] exp_c,
                       input logic exp_err, input logic exp_err_nr);
        if0.valid_i = 1'b1;
        if0.op_i    = op_v;
        if0.a_i     = av;
        if0.b_i     = bv;
        #1;
        check({tag, ".rdy"}, 64'(if0.ready_o), 64'd1);
        @(posedge clk); #1;
        if0.valid_i = 1'b0;
        check({tag, ".lat"}, 64'(if0.valid_o), 64'd0);
        @(posedge clk); #1;
        check({tag, ".vld"}, 64'(if0.valid_o), 64'd1);
        check({tag, ".c"}, 64'(if0.c_o), 64'(exp_c));
        check({tag, ".err"}, 64'(if0.range_err_o), 64'(exp_err));
        check({tag, ".err_nr"}, 64'(if_nr.range_err_o), 64'(exp_err_nr));
        @(posedge clk); #1;
        check({tag, ".drain"}, 64'(if0.valid_o), 64'd0);
    endtask

    logic        s_op [6];
    logic [22:0] s_a  [6];
    logic [22:0] s_b  [6];
    logic [22:0] s_c  [6];

    logic [22:0] exp23 [$];
    logic [31:0] exp32 [$];

    int          sent;
    int          recv;
    int          stall_left;
    int          cyc;
    bit          stall_seen;
    bit          stall_done;
    bit          saw_full;
    bit          acc;
    bit          cons;
    logic [22:0] held;

    initial begin
        if0.valid_i = 1'b0;
        if0.op_i    = 1'b0;
        if0.a_i     = '0;
        if0.b_i     = '0;
        if0.q_i     = Q;
        if0.ready_i = 1'b1;
        a32         = '0;
        b32         = '0;

        // Reset state
        #12;
        check("rst.valid", 64'(if0.valid_o), 64'd0);
        check("rst.c", 64'(if0.c_o), 64'd0);
        check("rst.err", 64'(if0.range_err_o), 64'd0);
        check("rst.ready", 64'(if0.ready_o), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed boundaries
        one("sub_wrap", 1'b1, 23'd5, 23'd7, 23'h7FDFFF, 1'b0, 1'b0);
        one("add_eq_q", 1'b0, 23'h7FE000, 23'd1, 23'd0, 1'b0, 1'b0);
        one("add_q_p1", 1'b0, 23'h7FE000, 23'd2, 23'd1, 1'b0, 1'b0);
        one("add_small", 1'b0, 23'd3, 23'd4, 23'd7, 1'b0, 1'b0);
        one("sub_equal", 1'b1, 23'h123456, 23'h123456, 23'd0, 1'b0, 1'b0);
        one("range", 1'b0, 23'h7FE001, 23'd0, 23'd0, 1'b1, 1'b0);

        // Streaming with a 4-cycle stall starting at the first result
        s_op = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        s_a  = '{23'd1, 23'd0, 23'h400000, 23'h100, 23'h7FE000, 23'd0};
        s_b  = '{23'd2, 23'd1, 23'h400000, 23'h010, 23'h7FE000, 23'h7FE000};
        s_c  = '{23'd3, 23'h7FE000, 23'h001FFF, 23'h0F0, 23'h7FDFFF, 23'd1};
        sent = 0; recv = 0; stall_left = 0;
        stall_seen = 0; stall_done = 0; saw_full = 0; held = '0;
        for (int k = 0; k < 40 && recv < 6; k++) begin
            if (!stall_seen && if0.valid_o) begin
                stall_seen = 1;
                stall_left = 4;
                held       = if0.c_o;
            end
            if0.ready_i = !(stall_left > 0);
            if0.valid_i = (sent < 6);
            if (sent < 6) begin
                if0.op_i = s_op[sent];
                if0.a_i  = s_a[sent];
                if0.b_i  = s_b[sent];
            end
            #1;
            check("strm.rdy", 64'(if0.ready_o),
                  64'(!((sent - recv) == 2 && stall_left > 0)));
            if (!if0.ready_o) saw_full = 1;
            if (stall_left > 0) begin
                check("strm.hold_c", 64'(if0.c_o), 64'(held));
                check("strm.hold_v", 64'(if0.valid_o), 64'd1);
            end
            if (stall_done && recv < 6) check("strm.tput", 64'(if0.valid_o), 64'd1);
            acc  = if0.valid_i && if0.ready_o;
            cons = if0.valid_o && if0.ready_i;
            if (cons) begin
                check("strm.data", 64'(if0.c_o), 64'(s_c[recv]));
                recv++;
            end
            if (acc) sent++;
            @(posedge clk); #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end
        end
        if0.valid_i = 1'b0;
        if0.ready_i = 1'b1;
        check("strm.sent", 64'(sent), 64'd6);
        check("strm.recv", 64'(recv), 64'd6);
        check("strm.full_seen", 64'(saw_full), 64'd1);
        @(posedge clk); #1;
        check("strm.no_dup", 64'(if0.valid_o), 64'd0);

        // Reset mid-stream discards in-flight tokens
        if0.valid_i = 1'b1; if0.op_i = 1'b0; if0.a_i = 23'd3; if0.b_i = 23'd4;
        @(posedge clk); #1;
        if0.a_i = 23'd1; if0.b_i = 23'd2;
        @(posedge clk); #1;
        if0.valid_i = 1'b0;
        check("mrst.pre_v", 64'(if0.valid_o), 64'd1);
        check("mrst.pre_c", 64'(if0.c_o), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.valid", 64'(if0.valid_o), 64'd0);
        check("mrst.c", 64'(if0.c_o), 64'd0);
        check("mrst.ready", 64'(if0.ready_o), 64'd1);
        @(posedge clk); #4;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("mrst.stale", 64'(if0.valid_o), 64'd0);
        end
        check("mrst.ready_after", 64'(if0.ready_o), 64'd1);

        // Random regression with scoreboard, both widths in lockstep
        sent = 0; recv = 0; cyc = 0;
        while (recv < NRND && cyc < 60000) begin
            if0.ready_i = ($urandom_range(3) != 0);
            if0.valid_i = (sent < NRND) && ($urandom_range(3) != 0);
            if0.op_i    = 1'($urandom_range(1));
            if0.a_i     = 23'($urandom % 32'(Q));
            if0.b_i     = 23'($urandom % 32'(Q));
            a32         = $urandom % Q32;
            b32         = $urandom % Q32;
            #1;
            if (if0.valid_o && if0.ready_i) begin
                if (exp23.size() == 0) begin
                    check("rnd.spurious", 64'd1, 64'd0);
                end else begin
                    check("rnd.c23", 64'(if0.c_o), 64'(exp23.pop_front()));
                    check("rnd.c32", 64'(if32.c_o), 64'(exp32.pop_front()));
                    check("rnd.v32", 64'(if32.valid_o), 64'd1);
                    check("rnd.err", 64'(if0.range_err_o), 64'd0);
                end
                recv++;
            end
            if (if0.valid_i && if0.ready_o) begin
                exp23.push_back(23'(mod_ref(if0.op_i, 64'(if0.a_i), 64'(if0.b_i), 64'(Q))));
                exp32.push_back(32'(mod_ref(if0.op_i, 64'(a32), 64'(b32), 64'(Q32))));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("rnd.done", 64'(recv), 64'(NRND));
        check("rnd.empty", 64'(exp23.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
